// File: rtl/gpu_instr_pkg.sv
`default_nettype none
// ============================================================================
// Module : gpu_instr_pkg
// Brief  : Draw-instruction field widths, packed instruction layout and
//          pack/unpack helpers shared by the command decoder, the instruction
//          queue and the raster engines. The queue itself is field-agnostic
//          and only uses INSTR_BITS.
// Rev    : 1.0  initial release
// ============================================================================
package gpu_instr_pkg;

    // Field widths mirrored from gpu_definitions
    localparam int WIDTH_BITS   = 10;   // x coordinates
    localparam int HEIGHT_BITS  = 10;   // y coordinates
    localparam int CHANNEL_BITS = 8;    // one colour channel
    localparam int OPCODE_BITS  = 4;
    localparam int RAD_BITS     = 8;
    localparam int OCT_BITS     = 3;

    localparam int INSTR_BITS = OCT_BITS + 3 * CHANNEL_BITS + RAD_BITS
                              + 2 * HEIGHT_BITS + 2 * WIDTH_BITS + OPCODE_BITS;

    // MSB..LSB: oct, b, g, r, rad, y2, x2, y1, x1, opcode
    typedef struct packed {
        logic [OCT_BITS-1:0]     oct;
        logic [CHANNEL_BITS-1:0] b;
        logic [CHANNEL_BITS-1:0] g;
        logic [CHANNEL_BITS-1:0] r;
        logic [RAD_BITS-1:0]     rad;
        logic [HEIGHT_BITS-1:0]  y2;
        logic [WIDTH_BITS-1:0]   x2;
        logic [HEIGHT_BITS-1:0]  y1;
        logic [WIDTH_BITS-1:0]   x1;
        logic [OPCODE_BITS-1:0]  opcode;
    } gpu_instr_t;

    function automatic logic [INSTR_BITS-1:0] pack_instr(input gpu_instr_t s);
        return s;
    endfunction

    function automatic gpu_instr_t unpack_instr(input logic [INSTR_BITS-1:0] w);
        return gpu_instr_t'(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : gpu_fifo_ctrl
// Brief  : Pointer / occupancy / status controller for the instruction queue.
//          Decides which push and pop requests are accepted and keeps the
//          sticky overflow and underflow flags.
// Ports  : clk, n_rst           clock, async active-low reset
//          push_i, pop_i        requests from producer / consumer
//          flush_i              discard all entries (highest priority)
//          clear_err_i          clear sticky flags
//          wr_en_o, wr_ptr_o    storage write strobe and address
//          rd_ptr_o             head address
//          empty_o, full_o, almost_full_o, count_o   occupancy status
//          overflow_o, underflow_o                   sticky error flags
// Rev    : 1.0  initial release
// ============================================================================
module gpu_fifo_ctrl #(
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int PTR_BITS  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic                flush_i,
    input  logic                clear_err_i,
    output logic                wr_en_o,
    output logic [PTR_BITS-1:0] wr_ptr_o,
    output logic [PTR_BITS-1:0] rd_ptr_o,
    output logic                empty_o,
    output logic                full_o,
    output logic                almost_full_o,
    output logic [PTR_BITS:0]   count_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam logic [PTR_BITS:0]   C_DEPTH   = (PTR_BITS+1)'(DEPTH);
    localparam logic [PTR_BITS:0]   C_AF      = (PTR_BITS+1)'(AF_THRESH);
    localparam logic [PTR_BITS:0]   C_CNT_ONE = (PTR_BITS+1)'(1);
    localparam logic [PTR_BITS-1:0] C_PTR_ONE = PTR_BITS'(1);

    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]   count_q,  count_d;
    logic                overflow_q,  overflow_d;
    logic                underflow_q, underflow_d;

    logic w_pop_acc;
    logic w_push_acc;

    // Status comes only from registered count, so push_i never reaches full_o.
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == C_DEPTH);
    assign almost_full_o = (count_q >= C_AF);

    // A pop on full frees the slot the push writes, so both may be accepted.
    assign w_pop_acc  = pop_i & ~empty_o & ~flush_i;
    assign w_push_acc = push_i & ~flush_i & (~full_o | w_pop_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push_acc) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            if (w_pop_acc)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            case ({w_push_acc, w_pop_acc})
                2'b10:   count_d = count_q + C_CNT_ONE;
                2'b01:   count_d = count_q - C_CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // Clear first so a same-cycle error event keeps the flag set.
        if (clear_err_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (push_i & ~flush_i & ~w_push_acc) overflow_d  = 1'b1;
        if (pop_i  & ~flush_i & empty_o)     underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_en_o     = w_push_acc;
    assign wr_ptr_o    = wr_ptr_q;
    assign rd_ptr_o    = rd_ptr_q;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule
`default_nettype wire

// File: rtl/gpu_instr_queue.sv
`default_nettype none
// ============================================================================
// Module : gpu_instr_queue
// Brief  : Show-ahead instruction queue between the command decoder and the
//          raster engines. Holds the storage array and head read mux; all
//          control lives in gpu_fifo_ctrl.
// Ports  : clk, n_rst                  clock, async active-low reset
//          push_i, wr_data_i           write request and instruction word
//          pop_i                       consume head entry
//          flush_i, clear_err_i        discard all / clear sticky flags
//          rd_data_o                   head entry, 0 when empty
//          empty_o, full_o, almost_full_o, count_o   occupancy status
//          overflow_o, underflow_o     sticky error flags
// Rev    : 1.0  initial release
// ============================================================================
module gpu_instr_queue
    import gpu_instr_pkg::*;
#(
    parameter int   WIDTH     = INSTR_BITS,
    parameter int   DEPTH     = 8,
    parameter int   AF_THRESH = 6,
    localparam int  PTR_BITS  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               push_i,
    input  logic [WIDTH-1:0]   wr_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic               clear_err_i,
    output logic [WIDTH-1:0]   rd_data_o,
    output logic               empty_o,
    output logic               full_o,
    output logic               almost_full_o,
    output logic [PTR_BITS:0]  count_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    logic                wr_en;
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;

    // Storage is deliberately not reset; validity is tracked by the count.
    logic [WIDTH-1:0] mem_q [DEPTH];

    gpu_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .PTR_BITS  (PTR_BITS)
    ) u_ctrl (
        .clk           (clk),
        .n_rst         (n_rst),
        .push_i        (push_i),
        .pop_i         (pop_i),
        .flush_i       (flush_i),
        .clear_err_i   (clear_err_i),
        .wr_en_o       (wr_en),
        .wr_ptr_o      (wr_ptr),
        .rd_ptr_o      (rd_ptr),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr] <= wr_data_i;
    end

    // Masking on empty hides stale storage after reset or flush.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_gpu_instr_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_gpu_instr_queue
// Brief  : Directed self-checking bench for gpu_instr_queue.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gpu_instr_queue;
    import gpu_instr_pkg::*;

    localparam int W = INSTR_BITS;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         push_i, pop_i, flush_i, clear_err_i;
    logic [W-1:0] wr_data_i;
    logic [W-1:0] rd_data_o;
    logic         empty_o, full_o, almost_full_o, overflow_o, underflow_o;
    logic [3:0]   count_o;

    int n_checks = 0;
    int n_errors = 0;

    gpu_instr_queue #(.WIDTH(W), .DEPTH(8), .AF_THRESH(6)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .push_i        (push_i),
        .wr_data_i     (wr_data_i),
        .pop_i         (pop_i),
        .flush_i       (flush_i),
        .clear_err_i   (clear_err_i),
        .rd_data_o     (rd_data_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pu, input logic [W-1:0] d, input logic po,
                         input logic fl, input logic ce);
        push_i = pu; wr_data_i = d; pop_i = po; flush_i = fl; clear_err_i = ce;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_status(input string tag, input logic [3:0] cnt,
                              input logic emp, input logic ful, input logic af);
        chkc({tag, "_count"}, count_o, cnt);
        chk1({tag, "_empty"}, empty_o, emp);
        chk1({tag, "_full"},  full_o,  ful);
        chk1({tag, "_af"},    almost_full_o, af);
    endtask

    gpu_instr_t s_in;
    gpu_instr_t s_out;

    initial begin
        n_rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk_status("rst", 4'd0, 1'b1, 1'b0, 1'b0);
        chkd("rst_rd", rd_data_o, '0);
        chk1("rst_ovf", overflow_o, 1'b0);
        chk1("rst_udf", underflow_o, 1'b0);
        n_rst = 1'b1;
        step();

        // 1: fill to full, head stays first word
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
            step();
            chk_status("fill", 4'(i), 1'b0, (i == 8), (i >= 6));
            chkd("fill_head", rd_data_o, W'(1));
        end

        // 2: push on full is rejected, then drain in order
        drive(1'b1, W'(9), 1'b0, 1'b0, 1'b0);
        step();
        chk1("ovf_set", overflow_o, 1'b1);
        chkc("ovf_count", count_o, 4'd8);
        chkd("ovf_head", rd_data_o, W'(1));
        for (int i = 1; i <= 8; i++) begin
            chkd("drain_data", rd_data_o, W'(i));
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            step();
        end
        idle();
        chk_status("drained", 4'd0, 1'b1, 1'b0, 1'b0);
        chkd("drained_rd", rd_data_o, '0);
        chk1("drained_udf", underflow_o, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        chk1("clr_ovf", overflow_o, 1'b0);

        // 3: push+pop on full, then drain through the wrap
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        chkc("refill_count", count_o, 4'd8);
        drive(1'b1, W'('hA), 1'b1, 1'b0, 1'b0);
        step();
        chkc("pp_count", count_o, 4'd8);
        chkd("pp_head", rd_data_o, W'(2));
        chk1("pp_no_ovf", overflow_o, 1'b0);
        for (int i = 2; i <= 9; i++) begin
            chkd("wrap_data", rd_data_o, (i == 9) ? W'('hA) : W'(i));
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            step();
        end
        idle();
        chk_status("wrap_end", 4'd0, 1'b1, 1'b0, 1'b0);

        // 4: underflow, clear colliding with new error, plain clear
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
        chk1("udf_set", underflow_o, 1'b1);
        chkc("udf_count", count_o, 4'd0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step();
        chk1("udf_clr_collide", underflow_o, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        chk1("udf_clr", underflow_o, 1'b0);
        chk1("ovf_clr", overflow_o, 1'b0);

        // write-to-empty with pop: push wins, pop flags underflow
        drive(1'b1, W'('h77), 1'b1, 1'b0, 1'b0);
        step();
        chkc("we_count", count_o, 4'd1);
        chkd("we_head", rd_data_o, W'('h77));
        chk1("we_udf", underflow_o, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        chk1("we_clr", underflow_o, 1'b0);

        // 5: count=5 then flush with push and pop asserted
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'('h11 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        chkc("pre_flush_count", count_o, 4'd5);
        drive(1'b1, W'('h99), 1'b1, 1'b1, 1'b0);
        step();
        idle();
        chk_status("flush", 4'd0, 1'b1, 1'b0, 1'b0);
        chkd("flush_rd", rd_data_o, '0);
        chk1("flush_ovf", overflow_o, 1'b0);
        chk1("flush_udf", underflow_o, 1'b0);

        // 6: async reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'('h21 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        idle();
        chkc("pre_rst_count", count_o, 4'd3);
        chkd("pre_rst_head", rd_data_o, W'('h21));
        #2;
        n_rst = 1'b0;
        #1;
        chk_status("async_rst", 4'd0, 1'b1, 1'b0, 1'b0);
        chkd("async_rst_rd", rd_data_o, '0);
        step();
        n_rst = 1'b1;
        drive(1'b1, W'('h55), 1'b0, 1'b0, 1'b0);
        step();
        idle();
        chkd("post_rst_head", rd_data_o, W'('h55));
        chkc("post_rst_count", count_o, 4'd1);

        // packed instruction passes through intact behind the head
        s_in = '{oct: 3'd5, b: 8'h12, g: 8'h34, r: 8'h56, rad: 8'h9A,
                 y2: 10'h3FF, x2: 10'h200, y1: 10'h001, x1: 10'h155, opcode: 4'hC};
        drive(1'b1, pack_instr(s_in), 1'b1, 1'b0, 1'b0);
        step();
        idle();
        s_out = unpack_instr(rd_data_o);
        chkd("instr_word", rd_data_o, W'({3'd5, 8'h12, 8'h34, 8'h56, 8'h9A,
                                          10'h3FF, 10'h200, 10'h001, 10'h155, 4'hC}));
        chkc("instr_opcode", s_out.opcode, 4'hC);
        chkc("instr_count", count_o, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
